// File: rtl/wash_panel_ctrl.sv
// -----------------------------------------------------------------------------
// wash_panel_ctrl
//   Front-panel controller for the washing machine. Debounces the raw start and
//   pause buttons, supervises the door sensor and lock, and produces the
//   level-sensitive run enable that feeds the sequencer's start input. The
//   sequencer's done pulse ends the cycle and sounds the buzzer.
//
// Ports
//   clk          in   single rising-edge clock
//   reset_n      in   asynchronous assert, synchronous release, active-low
//   start_btn    in   raw start button (active high, synchronous to clk)
//   pause_btn    in   raw pause button (active high)
//   door_closed  in   door sensor, 1 = closed
//   done         in   sequencer STOP-stage pulse
//   run          out  sequencer start enable (high only in RUN)
//   pause        out  paused indicator / sequencer pause
//   door_lock    out  door lock solenoid
//   buzzer       out  end-of-cycle buzzer
//   busy         out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module wash_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCK_DELAY      = 2,
  parameter int BUZZ_CYCLES     = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_btn,
  input  logic pause_btn,
  input  logic door_closed,
  input  logic done,
  output logic run,
  output logic pause,
  output logic door_lock,
  output logic buzzer,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOCKING = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSED  = 3'd3,
    S_FINISH  = 3'd4
  } state_e;

  localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] LOCK_LD  = 4'(LOCK_DELAY - 1);
  localparam logic [3:0] BUZZ_LD  = 4'(BUZZ_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] timer_q, timer_d;

  logic [3:0] start_cnt_q, start_cnt_d;
  logic [3:0] pause_cnt_q, pause_cnt_d;
  logic       start_press_q, start_press_d;
  logic       pause_press_q, pause_press_d;

  // Saturating run-length counter: a low sample clears it, so a release
  // re-arms the debouncer while a held button stays parked at the maximum.
  function automatic logic [3:0] deb_next(input logic btn, input logic [3:0] cnt);
    logic [3:0] nxt;
    if (!btn) begin
      nxt = 4'd0;
    end else if (cnt < DEB_MAX) begin
      nxt = cnt + 4'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // The press pulse is registered on the same edge at which the counter
  // reaches its maximum, so it is visible for exactly the following cycle.
  always_comb begin
    start_cnt_d   = deb_next(start_btn, start_cnt_q);
    pause_cnt_d   = deb_next(pause_btn, pause_cnt_q);
    start_press_d = start_btn && (start_cnt_q == DEB_LAST);
    pause_press_d = pause_btn && (pause_cnt_q == DEB_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_cnt_q   <= 4'd0;
      pause_cnt_q   <= 4'd0;
      start_press_q <= 1'b0;
      pause_press_q <= 1'b0;
    end else begin
      start_cnt_q   <= start_cnt_d;
      pause_cnt_q   <= pause_cnt_d;
      start_press_q <= start_press_d;
      pause_press_q <= pause_press_d;
    end
  end

  // State register and the shared LOCKING/FINISH down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= 4'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic. The timer is loaded on entry to a timed state and the
  // state exits on the edge at which the timer already reads zero.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (start_press_q && door_closed) begin
          state_d = S_LOCKING;
          timer_d = LOCK_LD;
        end
      end
      S_LOCKING: begin
        // An opening door takes priority over the lock timer expiring.
        if (!door_closed) begin
          state_d = S_IDLE;
          timer_d = 4'd0;
        end else if (timer_q == 4'd0) begin
          state_d = S_RUN;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_RUN: begin
        // done wins over pause or door opening; start presses are irrelevant.
        if (done) begin
          state_d = S_FINISH;
          timer_d = BUZZ_LD;
        end else if (pause_press_q || !door_closed) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if ((start_press_q || pause_press_q) && door_closed) begin
          state_d = S_RUN;
        end
      end
      S_FINISH: begin
        if (timer_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 4'd0;
      end
    endcase
  end

  // Moore output decode; because it is combinational from the state register,
  // an asserted reset clears run and door_lock without waiting for a clock.
  always_comb begin
    run       = 1'b0;
    pause     = 1'b0;
    door_lock = 1'b0;
    buzzer    = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_LOCKING: begin
        door_lock = 1'b1;
        busy      = 1'b1;
      end
      S_RUN: begin
        run       = 1'b1;
        door_lock = 1'b1;
        busy      = 1'b1;
      end
      S_PAUSED: begin
        pause     = 1'b1;
        door_lock = 1'b1;
        busy      = 1'b1;
      end
      S_FINISH: begin
        buzzer = 1'b1;
        busy   = 1'b1;
      end
      default: begin
        run = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for wash_panel_ctrl (default parameters). A behavioural model tracks
// button run lengths and time-in-state as plain edge counts; a compare process
// checks every output on every unreset cycle, and directed scenarios add
// literal expectations. Output vector order: {run, pause, door_lock, buzzer, busy}.
// -----------------------------------------------------------------------------
module tb_wash_panel_ctrl;

  localparam int DEB   = 4;
  localparam int LOCKD = 2;
  localparam int BUZZ  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_btn = 1'b0;
  logic pause_btn = 1'b0;
  logic door_closed = 1'b1;
  logic done = 1'b0;
  logic run, pause, door_lock, buzzer, busy;
  logic [4:0] dut_o;

  int vectors = 0;
  int miscompares = 0;

  wash_panel_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .LOCK_DELAY     (LOCKD),
    .BUZZ_CYCLES    (BUZZ)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .door_closed(door_closed),
    .done       (done),
    .run        (run),
    .pause      (pause),
    .door_lock  (door_lock),
    .buzzer     (buzzer),
    .busy       (busy)
  );

  assign dut_o = {run, pause, door_lock, buzzer, busy};

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_LOCK = 1, M_RUN = 2, M_PAUSE = 3, M_FIN = 4;
  int m_state = M_IDLE;
  int m_next  = M_IDLE;
  int m_edge  = 0;
  int m_entry = 0;
  int run_s   = 0;
  int run_p   = 0;
  bit sp      = 1'b0;
  bit pp      = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = M_IDLE;
      m_edge  = 0;
      m_entry = 0;
      run_s   = 0;
      run_p   = 0;
      sp      = 1'b0;
      pp      = 1'b0;
    end else begin
      m_edge = m_edge + 1;
      m_next = m_state;
      case (m_state)
        M_IDLE:  if (sp && door_closed) m_next = M_LOCK;
        M_LOCK:  if (!door_closed) m_next = M_IDLE;
                 else if (m_edge - m_entry == LOCKD) m_next = M_RUN;
        M_RUN:   if (done) m_next = M_FIN;
                 else if (pp || !door_closed) m_next = M_PAUSE;
        M_PAUSE: if ((sp || pp) && door_closed) m_next = M_RUN;
        M_FIN:   if (m_edge - m_entry == BUZZ) m_next = M_IDLE;
        default: m_next = M_IDLE;
      endcase
      if (m_next != m_state) m_entry = m_edge;
      m_state = m_next;
      // A press is the moment a button's unbroken high run reaches DEB samples.
      run_s = start_btn ? ((run_s < 1000) ? run_s + 1 : run_s) : 0;
      run_p = pause_btn ? ((run_p < 1000) ? run_p + 1 : run_p) : 0;
      sp = (run_s == DEB);
      pp = (run_p == DEB);
    end
  end

  function automatic logic [4:0] model_out(input int st);
    case (st)
      M_LOCK:  return 5'b00101;
      M_RUN:   return 5'b10101;
      M_PAUSE: return 5'b01101;
      M_FIN:   return 5'b00011;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b (run,pause,lock,buzz,busy)",
               name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) chk("model", dut_o, model_out(m_state));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a button for exactly DEB edges then release; the state reacts on the
  // release edge, so on return the new state is visible.
  task automatic press(input bit is_start);
    if (is_start) start_btn = 1'b1; else pause_btn = 1'b1;
    repeat (DEB) tick();
    start_btn = 1'b0;
    pause_btn = 1'b0;
    tick();
  endtask

  task automatic go_run();
    press(1'b1);
    repeat (LOCKD) tick();
    chk("reach_run", dut_o, 5'b10101);
  endtask

  task automatic async_reset(input string name);
    #2 reset_n = 1'b0;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    done = 1'b0;
    #1 chk(name, dut_o, 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] bounce;
    bounce = 8'b1110_1110;

    repeat (2) @(negedge clk);
    chk("reset_state", dut_o, 5'b00000);
    reset_n = 1'b1;
    tick();

    // Normal start: start high for edges 0..5.
    start_btn = 1'b1;
    repeat (4) tick();                 // edges 0..3
    chk("lock_not_yet_e3", dut_o, 5'b00000);
    tick();                            // edge 4
    chk("lock_at_e4", dut_o, 5'b00101);
    tick();                            // edge 5
    chk("no_run_e5", dut_o, 5'b00101);
    start_btn = 1'b0;
    tick();                            // edge 6
    chk("run_at_e6", dut_o, 5'b10101);

    // Pause / resume / safety stop.
    press(1'b0);
    chk("pause_press", dut_o, 5'b01101);
    press(1'b1);
    chk("resume_start", dut_o, 5'b10101);
    door_closed = 1'b0;
    tick();
    chk("door_safety_stop", dut_o, 5'b01101);
    press(1'b1);
    chk("start_door_open", dut_o, 5'b01101);
    door_closed = 1'b1;
    press(1'b1);
    chk("resume_door_closed", dut_o, 5'b10101);

    // Completion.
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("finish_n", dut_o, 5'b00011);
    tick();
    chk("finish_n1", dut_o, 5'b00011);
    tick();
    chk("finish_n2", dut_o, 5'b00011);
    tick();
    chk("idle_n3", dut_o, 5'b00000);

    // Bounce rejection.
    for (int i = 7; i >= 0; i--) begin
      start_btn = bounce[i];
      tick();
      chk("bounce", dut_o, 5'b00000);
    end
    start_btn = 1'b0;
    repeat (2) tick();
    chk("bounce_end", dut_o, 5'b00000);

    // done collides with a pause press.
    go_run();
    pause_btn = 1'b1;
    repeat (DEB) tick();
    pause_btn = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_beats_pause", dut_o, 5'b00011);
    repeat (BUZZ) tick();
    chk("collision_idle", dut_o, 5'b00000);

    // Door opens during LOCKING.
    press(1'b1);
    chk("locking", dut_o, 5'b00101);
    door_closed = 1'b0;
    tick();
    chk("locking_door_open", dut_o, 5'b00000);
    door_closed = 1'b1;
    repeat (3) tick();
    chk("locking_abort_stays", dut_o, 5'b00000);

    // Reset mid-RUN and mid-FINISH.
    go_run();
    async_reset("reset_mid_run");
    tick();
    go_run();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("finish_before_reset", dut_o, 5'b00011);
    async_reset("reset_mid_finish");
    tick();
    press(1'b1);
    chk("restart_locking", dut_o, 5'b00101);
    repeat (LOCKD) tick();

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 6) == 0) pause_btn = ~pause_btn;
      if ($urandom_range(0, 24) == 0) door_closed = ~door_closed;
      done = ($urandom_range(0, 19) == 0);
      if (c == 2500) async_reset("reset_random");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wash_panel_ctrl.md
# wash_panel_ctrl

Front-panel controller for the washing-machine datapath. It debounces the raw start and pause buttons and supervises the door sensor and lock. It produces the level-sensitive `run` enable that feeds the washing-machine sequencer's `start` input, and consumes that sequencer's `done` to end the cycle and sound the buzzer. It sits directly upstream of the sequencer; the sequencer advances only while `run` is high.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive high samples required to register a button press. Legal range 1–15.
- `LOCK_DELAY`, default 2: cycles the door lock is engaged before `run` asserts. Legal range 1–15.
- `BUZZ_CYCLES`, default 3: cycles `buzzer` stays high at end of cycle. Legal range 1–15.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  raw start button, active high, assumed synchronous to `clk`.
- `pause_btn`  in  1  raw pause button, active high.
- `door_closed`  in  1  door sensor; 1 means closed.
- `done`  in  1  from the sequencer; high for the one cycle it is in its STOP stage.
- `run`  out  1  drives the sequencer's `start`.
- `pause`  out  1  high while paused; drives the panel LED and the sequencer's `pause`.
- `door_lock`  out  1  door lock solenoid.
- `buzzer`  out  1  end-of-cycle buzzer.
- `busy`  out  1  high in any state other than IDLE.

## Operation
Debouncers (one per button, identical):
- Counter width is 4 bits and saturates at `DEBOUNCE_CYCLES`.
- A sample of 1 increments the counter; a sample of 0 clears it.
- The registered press pulse is high for exactly one cycle, following the edge at which the counter reaches `DEBOUNCE_CYCLES`.
- Holding the button produces no further pulses. Release (one low sample) re-arms the debouncer.

FSM states are IDLE, LOCKING, RUN, PAUSED and FINISH. Outputs are a Moore decode of the state register:
- IDLE: all outputs 0.
- LOCKING: `door_lock`=1, `busy`=1.
- RUN: `run`=1, `door_lock`=1, `busy`=1.
- PAUSED: `pause`=1, `door_lock`=1, `busy`=1.
- FINISH: `buzzer`=1, `busy`=1; lock released.

Transitions:
- IDLE → LOCKING on a start press with `door_closed`=1. A start press with the door open is ignored. Pause presses are ignored.
- LOCKING → RUN after exactly `LOCK_DELAY` cycles in LOCKING.
- LOCKING → IDLE if `door_closed`=0 is sampled; the timer clears.
- RUN → FINISH when `done`=1 is sampled. Because `run` is still high on that edge, the sequencer leaves STOP at the same edge.
- RUN → PAUSED on a pause press, or when `door_closed`=0 is sampled (safety stop).
- PAUSED → RUN on a start press or pause press with `door_closed`=1. Presses with the door open are ignored and the state stays PAUSED.
- FINISH → IDLE after exactly `BUZZ_CYCLES` cycles.

Simultaneous events in RUN:
- `done` beats a pause press or a door opening.
- Pause press beats start press.

Other rules:
- Presses that arrive while in LOCKING or FINISH are discarded, not queued.
- One 4-bit down-counter is shared by LOCKING and FINISH. It loads `LOCK_DELAY`-1 or `BUZZ_CYCLES`-1 on state entry and the state exits when the counter reads 0.

## Timing
- Reset (async assert, synchronous release) puts all outputs at 0, the state at IDLE, and all counters at 0. Reset mid-operation drops `run` and `door_lock` immediately.
- Press latency: with a button high from sample edge k onward, the pulse is high in the cycle after edge k+`DEBOUNCE_CYCLES`-1. The state changes at the edge k+`DEBOUNCE_CYCLES`.
- With default parameters, `start_btn` sampled high at edges 0–3 gives LOCKING from edge 4 and RUN from edge 6 (`run`=1).
- `done` sampled at edge n gives `run`=0 and `buzzer`=1 from edge n, and IDLE at edge n+`BUZZ_CYCLES`.
- Door opening sampled at edge n in RUN gives `run`=0 from edge n.

## Test plan
- **Normal start.** Defaults, `door_closed`=1, `start_btn` high for edges 0–5. Required: `door_lock` rises at edge 4, `run` rises at edge 6, and exactly one press is registered.
- **Bounce rejection.** `start_btn` pattern 1,1,1,0,1,1,1,0 per edge. Required: no press, state stays IDLE, all outputs 0.
- **Pause/resume and safety stop.** In RUN, press pause: `run`=0 and `pause`=1. Press start: back to RUN. In RUN, drop `door_closed`: PAUSED the same edge. Press start with the door still open: stays PAUSED. Close the door and press start: RUN.
- **Completion.** In RUN, assert `done` for one cycle at edge n. Required: `buzzer`=1 for edges n to n+2, `door_lock`=0 from edge n, and IDLE with `busy`=0 at edge n+3.
- **Collisions.** `done` together with a pause press gives FINISH. The door opening during LOCKING gives IDLE with the lock released.
- **Reset.** Assert `reset_n`=0 mid-RUN and mid-FINISH. Required: all outputs 0 asynchronously. After release, a fresh start press restarts from LOCKING.
